// File: rtl/param_cache_ctrl_if.sv
`default_nettype none
// ============================================================================
// param_cache_ctrl_if : core load/store port and backing-memory port bundle
// Rev 1.0
// ============================================================================
interface param_cache_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int LANES  = 4
);
  localparam int DW = 8 * LANES;

  logic              ren;
  logic              wen;
  logic              flush;
  logic [ADDR_W-1:0] addr;
  logic [DW-1:0]     din;
  logic [LANES-1:0]  be;
  logic              cache_rdy;
  logic [DW-1:0]     dout;
  logic              dout_vld;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DW-1:0]     mem_din;
  logic [LANES-1:0]  mem_be;
  logic [DW-1:0]     mem_dout;
  logic              mem_rdy;

  modport slave (
    input  ren, wen, flush, addr, din, be, mem_dout, mem_rdy,
    output cache_rdy, dout, dout_vld, mem_ren, mem_wen, mem_addr, mem_din, mem_be
  );

  modport master (
    output ren, wen, flush, addr, din, be, mem_dout, mem_rdy,
    input  cache_rdy, dout, dout_vld, mem_ren, mem_wen, mem_addr, mem_din, mem_be
  );
endinterface
`default_nettype wire

// File: rtl/param_cache_ctrl.sv
`default_nettype none
// ============================================================================
// param_cache_ctrl : direct-mapped, write-through, no-write-allocate cache
// Rev 1.0
// ============================================================================
module param_cache_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int LANES   = 4,
  parameter int INDEX_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  param_cache_ctrl_if.slave bus
);
  localparam int DW    = 8 * LANES;
  localparam int OFF_W = $clog2(LANES);
  localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
  localparam int DEPTH = 1 << INDEX_W;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LANES - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_RD, WR_MEM, FLUSH} state_t;

  state_t              r_state, w_state_nx;
  logic                r_cache_rdy;
  logic [ADDR_W-1:0]   r_addr;
  logic [DW-1:0]       r_din;
  logic [LANES-1:0]    r_be;
  logic                r_is_wr;
  logic [DW-1:0]       r_dout;
  logic                r_fill_vld;
  logic [INDEX_W-1:0]  r_flush_cnt;
  logic [DEPTH-1:0]    r_valid;
  logic [TAG_W-1:0]    r_rd_tag;
  logic [DW-1:0]       w_rd_line;
  logic [INDEX_W-1:0]  w_idx_in, w_idx_q;
  logic [TAG_W-1:0]    w_tag_q;
  logic                w_accept, w_hit, w_rd_hit, w_wr_hit, w_fill;
  logic                w_mem_ren, w_mem_wen, w_dout_vld;
  logic [DW-1:0]       w_dout;

  assign w_idx_in = bus.addr[OFF_W+INDEX_W-1:OFF_W];
  assign w_idx_q  = r_addr[OFF_W+INDEX_W-1:OFF_W];
  assign w_tag_q  = r_addr[ADDR_W-1:OFF_W+INDEX_W];
  assign w_accept = (r_state == IDLE) && r_cache_rdy && (bus.flush || bus.wen || bus.ren);
  assign w_hit    = r_valid[w_idx_q] && (r_rd_tag == w_tag_q);
  assign w_rd_hit = (r_state == LOOKUP) && !r_is_wr && w_hit;
  assign w_wr_hit = (r_state == LOOKUP) && r_is_wr && w_hit;
  assign w_fill   = (r_state == MISS_RD) && bus.mem_rdy;

  always_comb begin
    w_state_nx = r_state;
    w_mem_ren  = 1'b0;
    w_mem_wen  = 1'b0;
    w_dout_vld = r_fill_vld;
    w_dout     = r_dout;
    case (r_state)
      IDLE:    if (w_accept) w_state_nx = bus.flush ? FLUSH : LOOKUP;
      LOOKUP: begin
        if (r_is_wr) begin
          w_state_nx = (r_be == '0) ? IDLE : WR_MEM;
        end else if (w_hit) begin
          w_state_nx = IDLE;
          w_dout_vld = 1'b1;
          w_dout     = w_rd_line;
        end else begin
          w_state_nx = MISS_RD;
        end
      end
      MISS_RD: begin
        w_mem_ren = 1'b1;
        if (bus.mem_rdy) w_state_nx = IDLE;
      end
      WR_MEM: begin
        w_mem_wen = 1'b1;
        if (bus.mem_rdy) w_state_nx = IDLE;
      end
      FLUSH:   if (r_flush_cnt == '1) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cache_rdy <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
      r_be        <= '0;
      r_is_wr     <= 1'b0;
      r_dout      <= '0;
      r_fill_vld  <= 1'b0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cache_rdy <= (w_state_nx == IDLE);
      r_fill_vld  <= w_fill;
      if (w_accept) begin
        r_addr  <= bus.addr;
        r_din   <= bus.din;
        r_be    <= bus.be;
        r_is_wr <= bus.wen;
      end
      if (w_fill)        r_dout <= bus.mem_dout;
      else if (w_rd_hit) r_dout <= w_rd_line;
      r_flush_cnt <= (r_state == FLUSH) ? r_flush_cnt + INDEX_W'(1) : '0;
    end
  end

  // Valid bits are the only array state that must be cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_valid <= '0;
    else if (r_state == FLUSH) r_valid[r_flush_cnt] <= 1'b0;
    else if (w_fill)           r_valid[w_idx_q] <= 1'b1;
  end

  logic [TAG_W-1:0] tag_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (w_fill)   tag_mem[w_idx_q] <= w_tag_q;
    if (w_accept) r_rd_tag <= tag_mem[w_idx_in];
  end

  // One byte-wide array per lane so byte enables map onto independent writes.
  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] r_rd_byte;
      always_ff @(posedge clk) begin
        if (w_fill)                    lane_mem[w_idx_q] <= bus.mem_dout[8*i +: 8];
        else if (w_wr_hit && r_be[i])  lane_mem[w_idx_q] <= r_din[8*i +: 8];
        if (w_accept)                  r_rd_byte <= lane_mem[w_idx_in];
      end
      assign w_rd_line[8*i +: 8] = r_rd_byte;
    end
  endgenerate

  assign bus.cache_rdy = r_cache_rdy;
  assign bus.dout      = w_dout;
  assign bus.dout_vld  = w_dout_vld;
  assign bus.mem_ren   = w_mem_ren;
  assign bus.mem_wen   = w_mem_wen;
  assign bus.mem_addr  = r_addr & ~OFF_MASK;
  assign bus.mem_din   = r_din;
  assign bus.mem_be    = r_be;
endmodule
`default_nettype wire
